// File: rtl/wave_sched_pkg.sv
// Shared types and default sizing for the wave/download SDRAM scheduler.
package wave_sched_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_CH_AW   = 20;
    localparam int DEF_SD_AW   = 25;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } kind_e;

endpackage

// File: rtl/wave_sdram_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant, wrapping modulo NCH.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [$clog2(NCH)-1:0] grant,
    output logic                   valid
);

    localparam int PW = $clog2(NCH);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            if (!valid && req[(int'(last) + i) % NCH]) begin
                valid = 1'b1;
                grant = PW'((int'(last) + i) % NCH);
            end
        end
    end

endmodule

// File: rtl/wave_sdram_sched.sv
// Shares one SDRAM port between a buffered download writer (priority) and
// round-robin channel readers; one command in flight, guarded by a watchdog.
module wave_sdram_sched
    import wave_sched_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int CH_AW   = DEF_CH_AW,
    parameter int SD_AW   = DEF_SD_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dl_active,
    input  logic                 dl_wr,
    input  logic [SD_AW-1:0]     dl_addr,
    input  logic [7:0]           dl_data,
    output logic                 dl_wait,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH*CH_AW-1:0] ch_addr,
    output logic [NCH-1:0]       ch_ack,
    output logic [15:0]          ch_data,
    output logic [SD_AW-1:0]     sd_addr,
    output logic                 sd_rd,
    output logic                 sd_we,
    output logic [7:0]           sd_din,
    input  logic [15:0]          sd_dout,
    input  logic                 sd_ack,
    output logic                 err
);

    localparam int PW = $clog2(NCH);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [PW-1:0]    gnt_q, gnt_d, rr_q, rr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             buf_full_q, buf_full_d;
    logic [SD_AW-1:0] buf_addr_q, buf_addr_d, sd_addr_q, sd_addr_d;
    logic [7:0]       buf_data_q, buf_data_d, sd_din_q, sd_din_d;
    logic             sd_rd_q, sd_rd_d, sd_we_q, sd_we_d;
    logic             err_q, err_d;
    logic [NCH-1:0]   ch_ack_q, ch_ack_d;
    logic [15:0]      ch_data_q, ch_data_d;
    logic [PW-1:0]    arb_grant;
    logic             arb_valid;
    logic [CH_AW-1:0] sel_addr;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (ch_req),
        .last  (rr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign sel_addr = ch_addr[int'(arb_grant)*CH_AW +: CH_AW];

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        sd_addr_d  = sd_addr_q;
        sd_din_d   = sd_din_q;
        err_d      = err_q;
        ch_data_d  = ch_data_q;
        sd_rd_d    = 1'b0;
        sd_we_d    = 1'b0;
        ch_ack_d   = '0;

        // A strobe into an occupied buffer is dropped and flagged.
        if (dl_wr) begin
            if (buf_full_q) begin
                err_d = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_addr_d = dl_addr;
                buf_data_d = dl_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    sd_we_d   = 1'b1;
                    sd_addr_d = buf_addr_q;
                    sd_din_d  = buf_data_q;
                    kind_d    = WR;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end else if (!dl_active && arb_valid) begin
                    sd_rd_d   = 1'b1;
                    sd_addr_d = {{(SD_AW-CH_AW){1'b0}}, sel_addr};
                    gnt_d     = arb_grant;
                    rr_d      = arb_grant;
                    kind_d    = RD;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A timed-out read still acks so the channel never stalls; data reads as zero.
                if (sd_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    if (!sd_ack) err_d = 1'b1;
                    if (kind_q == RD) begin
                        ch_ack_d[gnt_q] = 1'b1;
                        ch_data_d       = sd_ack ? sd_dout : 16'h0000;
                    end else begin
                        buf_full_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            kind_q     <= RD;
            gnt_q      <= '0;
            rr_q       <= PW'(NCH - 1);
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            sd_addr_q  <= '0;
            sd_din_q   <= '0;
            sd_rd_q    <= 1'b0;
            sd_we_q    <= 1'b0;
            err_q      <= 1'b0;
            ch_ack_q   <= '0;
            ch_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            sd_addr_q  <= sd_addr_d;
            sd_din_q   <= sd_din_d;
            sd_rd_q    <= sd_rd_d;
            sd_we_q    <= sd_we_d;
            err_q      <= err_d;
            ch_ack_q   <= ch_ack_d;
            ch_data_q  <= ch_data_d;
        end
    end

    assign dl_wait = buf_full_q;
    assign ch_ack  = ch_ack_q;
    assign ch_data = ch_data_q;
    assign sd_addr = sd_addr_q;
    assign sd_rd   = sd_rd_q;
    assign sd_we   = sd_we_q;
    assign sd_din  = sd_din_q;
    assign err     = err_q;

endmodule

// File: tb/tb_wave_sdram_sched.sv
// Directed + randomized bench for wave_sdram_sched with an SDRAM responder and a
// transaction-level reference for grant order, latency and download priority.
module tb_wave_sdram_sched;

    localparam int NCH = 4, CH_AW = 20, SD_AW = 25, TIMEOUT = 64;

    logic                 clk = 1'b0, reset_n = 1'b0;
    logic                 dl_active = 1'b0, dl_wr = 1'b0;
    logic [SD_AW-1:0]     dl_addr = '0;
    logic [7:0]           dl_data = '0;
    logic                 dl_wait;
    logic [NCH-1:0]       ch_req = '0;
    logic [NCH*CH_AW-1:0] ch_addr = '0;
    logic [NCH-1:0]       ch_ack;
    logic [15:0]          ch_data;
    logic [SD_AW-1:0]     sd_addr;
    logic                 sd_rd, sd_we;
    logic [7:0]           sd_din;
    logic [15:0]          sd_dout = '0;
    logic                 sd_ack = 1'b0;
    logic                 err;

    int checks = 0, errors = 0, cyc = 0;
    int ack_delay = 0, stray_cnt = 0, stray_done = 0, rr_m;
    logic        fix_en = 1'b0;
    logic [15:0] fix_dout = '0;

    typedef struct { int cyc; logic rd; logic we; logic [SD_AW-1:0] addr; logic [7:0] din; } cmd_t;
    typedef struct { int cyc; logic [NCH-1:0] ack; logic [15:0] data; } ack_t;
    typedef struct { int cyc; logic [15:0] data; } rsp_t;
    cmd_t cmd_q[$];
    ack_t ack_q[$];
    rsp_t rsp_q[$];

    wave_sdram_sched #(.NCH(NCH), .CH_AW(CH_AW), .SD_AW(SD_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .ch_req(ch_req),
        .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_data(ch_data), .sd_addr(sd_addr),
        .sd_rd(sd_rd), .sd_we(sd_we), .sd_din(sd_din), .sd_dout(sd_dout),
        .sd_ack(sd_ack), .err(err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cmd_q.delete();
        ack_q.delete();
        rsp_q.delete();
    endtask

    task automatic wait_acks(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (ack_q.size() < n && k < bound) begin
            step();
            k++;
        end
        chk(tag, 32'(ack_q.size() >= n), 1);
    endtask

    task automatic wait_cmds(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (cmd_q.size() < n && k < bound) begin
            step();
            k++;
        end
        chk(tag, 32'(cmd_q.size() >= n), 1);
    endtask

    task automatic wait_dl_free(input string tag, output int fall_cyc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (dl_wait && k < 80);
        fall_cyc = cyc;
        chk(tag, 32'(dl_wait), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dl_wait"}, 32'(dl_wait), 0);
        chk({tag, "_ch_ack"},  32'(ch_ack),  0);
        chk({tag, "_ch_data"}, 32'(ch_data), 0);
        chk({tag, "_sd_rd"},   32'(sd_rd),   0);
        chk({tag, "_sd_we"},   32'(sd_we),   0);
        chk({tag, "_sd_addr"}, 32'(sd_addr), 0);
        chk({tag, "_sd_din"},  32'(sd_din),  0);
        chk({tag, "_err"},     32'(err),     0);
    endtask

    // Reference grant rule: first requester after the previous grant, wrapping.
    function automatic int model_grant(input logic [NCH-1:0] req, input int last);
        for (int i = 1; i <= NCH; i++)
            if (req[(last + i) % NCH]) return (last + i) % NCH;
        return -1;
    endfunction

    function automatic logic [SD_AW-1:0] chan_addr(input int ch);
        return SD_AW'(ch_addr[ch*CH_AW +: CH_AW]);
    endfunction

    // Check one completed read: grant, address, data and latency
    task automatic chk_read(input string tag, input int j, input int g);
        if (ack_q.size() > j && cmd_q.size() > j && rsp_q.size() > j) begin
            chk({tag, "_ack"},  32'(ack_q[j].ack), 32'(1 << g));
            chk({tag, "_rd"},   32'(cmd_q[j].rd), 1);
            chk({tag, "_addr"}, 32'(cmd_q[j].addr), 32'(chan_addr(g)));
            chk({tag, "_data"}, 32'(ack_q[j].data), 32'(rsp_q[j].data));
            chk({tag, "_lat"},  32'(ack_q[j].cyc), 32'(rsp_q[j].cyc + 1));
        end else begin
            chk({tag, "_logged"}, 0, 1);
        end
    endtask

    // SDRAM controller stand-in
    initial forever begin
        @(posedge clk);
        #1;
        if (stray_cnt != stray_done) begin
            stray_done++;
            sd_dout = 16'hDEAD;
            sd_ack  = 1'b1;
            @(posedge clk);
            #1;
            sd_ack = 1'b0;
        end else if ((sd_rd || sd_we) && ack_delay >= 0) begin
            if (ack_delay > 0) begin
                repeat (ack_delay) @(posedge clk);
                #1;
            end
            sd_dout = fix_en ? fix_dout : 16'($urandom);
            rsp_q.push_back('{cyc: cyc, data: sd_dout});
            sd_ack = 1'b1;
            @(posedge clk);
            #1;
            sd_ack = 1'b0;
        end
    end

    // Bus monitor
    initial forever begin
        @(negedge clk);
        if (sd_rd || sd_we) begin
            chk("rd_we_exclusive", 32'(sd_rd & sd_we), 0);
            cmd_q.push_back('{cyc: cyc, rd: sd_rd, we: sd_we, addr: sd_addr, din: sd_din});
        end
        if (ch_ack != '0) begin
            chk("ack_onehot", 32'($onehot(ch_ack)), 1);
            ack_q.push_back('{cyc: cyc, ack: ch_ack, data: ch_data});
        end
    end

    initial begin
        int t0, g, fall, lat;
        logic [NCH-1:0] req;

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        rr_m = NCH - 1;
        step();

        // Single read on channel 2, ack three cycles after the command
        clear_logs();
        ack_delay = 3; fix_en = 1'b1; fix_dout = 16'hBEEF;
        ch_addr[2*CH_AW +: CH_AW] = 20'h01234;
        ch_req = 4'b0100;
        t0 = cyc;
        wait_acks(1, 40, "t1_wait");
        ch_req = '0;
        g = model_grant(4'b0100, rr_m);
        chk_read("t1", 0, g);
        if (cmd_q.size() > 0 && ack_q.size() > 0) begin
            chk("t1_sd_addr",  32'(cmd_q[0].addr), 32'h0001234);
            chk("t1_cmd_cyc",  32'(cmd_q[0].cyc), 32'(t0 + 1));
            chk("t1_ack_cyc",  32'(ack_q[0].cyc), 32'(cmd_q[0].cyc + 4));
            chk("t1_ch_data",  32'(ack_q[0].data), 32'hBEEF);
        end
        rr_m = g;
        step();
        chk("t1_data_hold", 32'(ch_data), 32'hBEEF);

        // Round-robin with all channels requesting and immediate acks
        clear_logs();
        ack_delay = 0; fix_en = 1'b0;
        for (int i = 0; i < NCH; i++) ch_addr[i*CH_AW +: CH_AW] = CH_AW'($urandom);
        ch_req = 4'hF;
        wait_acks(8, 200, "t2_wait");
        ch_req = '0;
        for (int j = 0; j < 8; j++) begin
            g = model_grant(4'hF, rr_m);
            chk_read($sformatf("t2_%0d", j), j, g);
            rr_m = g;
        end
        step();
        chk("t2_no_extra", 32'(ack_q.size()), 8);

        // Randomized request patterns, addresses and ack delays
        for (int n = 0; n < 16; n++) begin
            clear_logs();
            req = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int i = 0; i < NCH; i++) ch_addr[i*CH_AW +: CH_AW] = CH_AW'($urandom);
            ack_delay = $urandom_range(0, 5);
            ch_req = req;
            wait_acks(1, 60, "t3_wait");
            ch_req = '0;
            g = model_grant(req, rr_m);
            chk_read($sformatf("t3_%0d", n), 0, g);
            rr_m = g;
        end
        chk("t3_err_clear", 32'(err), 0);

        // Download priority: writes go out, reads are held off
        clear_logs();
        ack_delay = 2;
        dl_active = 1'b1;
        ch_req = 4'hF;
        step();
        for (int i = 0; i < 4; i++) begin
            dl_addr = SD_AW'(32'h40000 + i);
            dl_data = 8'(8'hA0 + i);
            dl_wr = 1'b1;
            step();
            dl_wr = 1'b0;
            chk($sformatf("t4_wait_hi_%0d", i), 32'(dl_wait), 1);
            wait_dl_free($sformatf("t4_wait_lo_%0d", i), fall);
            if (rsp_q.size() > i) chk($sformatf("t4_fall_cyc_%0d", i), 32'(fall), 32'(rsp_q[i].cyc + 1));
            else chk($sformatf("t4_rsp_%0d", i), 0, 1);
        end
        repeat (5) step();
        chk("t4_cmd_cnt", 32'(cmd_q.size()), 4);
        for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
            chk($sformatf("t4_we_%0d", i),   32'(cmd_q[i].we), 1);
            chk($sformatf("t4_addr_%0d", i), 32'(cmd_q[i].addr), 32'h40000 + i);
            chk($sformatf("t4_din_%0d", i),  32'(cmd_q[i].din), 32'hA0 + i);
        end
        chk("t4_no_acks", 32'(ack_q.size()), 0);
        dl_active = 1'b0;
        ch_req = '0;
        step();

        // Watchdog: lost ack on a read
        clear_logs();
        ack_delay = -1;
        ch_addr[0 +: CH_AW] = CH_AW'($urandom);
        ch_req = 4'b0001;
        wait_acks(1, TIMEOUT + 20, "t5_wait");
        ch_req = '0;
        g = model_grant(4'b0001, rr_m);
        rr_m = g;
        if (ack_q.size() > 0 && cmd_q.size() > 0) begin
            lat = ack_q[0].cyc - cmd_q[0].cyc;
            chk("t5_ack",    32'(ack_q[0].ack), 32'(1 << g));
            chk("t5_data",   32'(ack_q[0].data), 0);
            chk("t5_lat_ok", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 1), 1);
        end
        chk("t5_err", 32'(err), 1);
        repeat (10) step();
        chk("t5_err_sticky", 32'(err), 1);
        clear_logs();
        ack_delay = 1;
        ch_req = 4'b0010;
        wait_acks(1, 40, "t5_next_wait");
        ch_req = '0;
        g = model_grant(4'b0010, rr_m);
        chk_read("t5_next", 0, g);
        rr_m = g;
        chk("t5_err_after", 32'(err), 1);

        // Reset while a read is outstanding, then a stray ack
        clear_logs();
        ack_delay = -1;
        ch_req = 4'b1000;
        wait_cmds(1, 20, "t6_cmd_wait");
        repeat (3) step();
        ch_req = '0;
        reset_n = 1'b0;
        step();
        chk_reset_outputs("t6");
        reset_n = 1'b1;
        rr_m = NCH - 1;
        step();
        stray_cnt++;
        repeat (6) step();
        chk("t6_no_ack", 32'(ack_q.size()), 0);

        // Write strobe together with a request in IDLE: read first, then the write
        clear_logs();
        ack_delay = 1;
        ch_addr[1*CH_AW +: CH_AW] = CH_AW'($urandom);
        ch_req = 4'b0010;
        dl_addr = SD_AW'(32'h1ABCDE);
        dl_data = 8'h5A;
        dl_wr = 1'b1;
        step();
        dl_wr = 1'b0;
        wait_acks(1, 40, "t7_wait");
        ch_req = '0;
        g = model_grant(4'b0010, rr_m);
        rr_m = g;
        wait_dl_free("t7_wait_lo", fall);
        chk("t7_cmd_cnt", 32'(cmd_q.size()), 2);
        if (cmd_q.size() >= 2) begin
            chk("t7_first_rd",   32'(cmd_q[0].rd), 1);
            chk("t7_first_addr", 32'(cmd_q[0].addr), 32'(chan_addr(g)));
            chk("t7_second_we",  32'(cmd_q[1].we), 1);
            chk("t7_second_addr", 32'(cmd_q[1].addr), 32'h1ABCDE);
            chk("t7_second_din", 32'(cmd_q[1].din), 32'h5A);
        end

        // Overrun: second strobe while the buffer is occupied
        clear_logs();
        ack_delay = 3;
        dl_active = 1'b1;
        chk("t8_err_pre", 32'(err), 0);
        dl_addr = SD_AW'(32'h0000111);
        dl_data = 8'h11;
        dl_wr = 1'b1;
        step();
        chk("t8_wait_hi", 32'(dl_wait), 1);
        dl_addr = SD_AW'(32'h0000222);
        dl_data = 8'h22;
        step();
        dl_wr = 1'b0;
        chk("t8_err", 32'(err), 1);
        wait_dl_free("t8_wait_lo", fall);
        repeat (5) step();
        chk("t8_cmd_cnt", 32'(cmd_q.size()), 1);
        if (cmd_q.size() > 0) begin
            chk("t8_addr", 32'(cmd_q[0].addr), 32'h111);
            chk("t8_din",  32'(cmd_q[0].din), 32'h11);
        end
        dl_active = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_sdram_sched.md
Name: wave_sdram_sched

Overview:
- Scheduler that shares the single-port SDRAM between the ROM/wave download path and NCH sample-playback channels.
- Download writes take strict priority. Channel reads are served round-robin and are blocked while a download is active.
- Sits between hps ioctl / sample voices and the sdram controller, replacing the hard-wired download/wave_rd mux.
- One command is outstanding at a time. A watchdog recovers from a lost controller ack.

Parameters:
- NCH, 4, number of playback channels (2..8).
- CH_AW, 20, channel word-address width; zero-extended to SD_AW.
- SD_AW, 25, SDRAM address width.
- TIMEOUT, 64, max cycles to wait for sd_ack before abort.

Ports:
- clk  in  1  system clock, shared with sdram controller.
- reset_n  in  1  synchronous, active-low reset.
- dl_active  in  1  download in progress (level).
- dl_wr  in  1  one-cycle write strobe.
- dl_addr  in  SD_AW  download byte address.
- dl_data  in  8  download byte.
- dl_wait  out  1  write buffer occupied; source must hold off the next dl_wr.
- ch_req  in  NCH  per-channel read request (level, held until ack).
- ch_addr  in  NCH*CH_AW  packed channel addresses; channel i at [i*CH_AW +: CH_AW].
- ch_ack  out  NCH  one-cycle ack, one-hot.
- ch_data  out  16  read data, valid with ch_ack.
- sd_addr  out  SD_AW  command address.
- sd_rd  out  1  one-cycle read command.
- sd_we  out  1  one-cycle write command.
- sd_din  out  8  write data.
- sd_dout  in  16  read data, valid when sd_ack=1.
- sd_ack  in  1  one-cycle command-complete pulse from controller.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; rr pointer=NCH-1; write buffer empty.
  - Outputs: dl_wait=0, ch_ack=0, ch_data=0, sd_rd=0, sd_we=0, sd_addr=0, sd_din=0, err=0.
  - A command in flight is abandoned; a late sd_ack is ignored in IDLE.
- Write buffer:
  - dl_wr captures dl_addr/dl_data into a 1-deep buffer and sets dl_wait the next cycle.
  - Buffer clears, and dl_wait drops, on the cycle after the write's sd_ack or timeout.
  - dl_wr while dl_wait=1 is a protocol violation: data is dropped and err is set.
- FSM states: IDLE, WAIT.
- IDLE, cycle T, priority order:
  1. Buffer full -> registered sd_we=1, sd_addr=buffer addr, sd_din=buffer data at T+1; go WAIT (kind=write).
  2. Else if !dl_active and |ch_req -> grant g = first requesting channel scanning from rr+1 modulo NCH. Latch g and ch_addr[g]. Registered sd_rd=1 and sd_addr={0, ch_addr[g]} at T+1; rr<=g; go WAIT (kind=read).
  3. Else stay IDLE.
- sd_rd and sd_we are high for exactly one cycle per command and never high together.
- WAIT:
  - Watchdog counter starts at 0 on entry and increments each cycle.
  - sd_ack on a read: next cycle ch_ack[g]=1 and ch_data=sd_dout (registered); return to IDLE.
  - sd_ack on a write: next cycle clear the buffer; return to IDLE.
  - Counter reaching TIMEOUT with no ack: set err. Read -> ch_ack[g]=1 with ch_data=16'h0000. Write -> buffer cleared. Return to IDLE.
- Latency: grant decision T; command at T+1; ack at T+1+k; ch_ack at T+2+k; next grant decision T+2+k; next command T+3+k.
- ch_req dropped after grant: the transaction still completes and ch_ack still pulses; the channel must ignore it.
- dl_active rising while a read is in WAIT: the read completes normally; no further reads are granted until dl_active falls.
- Simultaneous dl_wr and a channel request in IDLE: the buffer fills this cycle, so the read is decided this cycle and the write waits one full transaction.
- ch_data holds its last value between acks.

Decomposition:
- Package wave_sched_pkg:
  - FSM state enum (IDLE, WAIT); transaction kind enum (RD, WR).
  - Default NCH/CH_AW/SD_AW/TIMEOUT constants.
- One sub-module, rr_arbiter: NCH-wide round-robin with inputs req and last-grant pointer, outputs grant index and valid; purely combinational.
- Write buffer, watchdog and FSM stay in the top.

Test Plan:
- Single read: ch_req=4'b0100, ch2 addr=20'h01234, ack 3 cycles after sd_rd with sd_dout=16'hBEEF -> sd_addr=25'h0001234 at T+1; ch_ack=4'b0100 with ch_data=16'hBEEF exactly one cycle after sd_ack.
- Round-robin fairness: all four ch_req held, immediate acks -> grant order 0,1,2,3,0,... across 8 transactions; each ch_ack one-hot.
- Download priority: dl_active=1 with ch_req=4'b1111, 4 dl_wr to 0x40000..0x40003 with data 0xA0..0xA3, each issued after dl_wait=0 -> 4 sd_we with matching addr/data; zero sd_rd; dl_wait high from strobe+1 until ack+1.
- Timeout: read granted, sd_ack never asserted -> after TIMEOUT=64 cycles, ch_ack pulses with ch_data=0; err=1 and stays 1; next request is served normally.
- Reset mid-WAIT: reset_n=0 for one cycle during an outstanding read -> all outputs 0, no ch_ack; a subsequent stray sd_ack causes no ch_ack.
- Overrun: second dl_wr while dl_wait=1 -> err=1; only the first write appears on sd_we.
